// File: rtl/mem_model_pkg.sv
// Shared state encoding and command-word field layout for the memory model.
package mem_model_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Queue head layout is {rnw, count, addr}; offsets depend on the field widths.
  localparam int ADDR_LSB = 0;

  function automatic int cnt_lsb(input int addr_width);
    return addr_width;
  endfunction

  function automatic int rnw_bit(input int addr_width, input int cnt_width);
    return addr_width + cnt_width;
  endfunction

endpackage

// File: rtl/mem_model_burst_sched_if.sv
// Queue, word-port and data handshake bundle around the burst scheduler.
interface mem_model_burst_sched_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 12,
  parameter int DATA_WIDTH = 32
);
  logic                          q_empty;
  logic [ADDR_WIDTH+CNT_WIDTH:0] q_rdata;
  logic                          q_read;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic                          mem_write;
  logic                          mem_read;
  logic [DATA_WIDTH-1:0]         mem_writedata;
  logic [DATA_WIDTH-1:0]         mem_readdata;
  logic                          mem_wait;
  logic                          wd_valid;
  logic [DATA_WIDTH-1:0]         wd_data;
  logic                          wd_ready;
  logic                          rd_valid;
  logic [DATA_WIDTH-1:0]         rd_data;

  // Scheduler side.
  modport master (
    input  q_empty, q_rdata, mem_readdata, mem_wait, wd_valid, wd_data,
    output q_read, mem_addr, mem_write, mem_read, mem_writedata, wd_ready,
           rd_valid, rd_data
  );

  // Queue / memory / data-source side.
  modport slave (
    output q_empty, q_rdata, mem_readdata, mem_wait, wd_valid, wd_data,
    input  q_read, mem_addr, mem_write, mem_read, mem_writedata, wd_ready,
           rd_valid, rd_data
  );
endinterface

// File: rtl/mem_model_burst_addr_gen.sv
// Beat address and remaining-beat counter for one burst.
module mem_model_burst_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 12,
  parameter int ADDR_INCR  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [CNT_WIDTH-1:0]  load_cnt,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH:0]    beats_q, beats_d;

  // Load a new burst, or advance one beat; address wraps modulo 2^ADDR_WIDTH.
  always_comb begin
    addr_d  = addr_q;
    beats_d = beats_q;
    if (load) begin
      addr_d  = load_addr;
      // A zero count means the full 2^CNT_WIDTH beats, hence the extra bit.
      beats_d = (load_cnt == '0) ? {1'b1, {CNT_WIDTH{1'b0}}} : {1'b0, load_cnt};
    end else if (step) begin
      addr_d  = addr_q + ADDR_WIDTH'(ADDR_INCR);
      beats_d = beats_q - (CNT_WIDTH+1)'(1);
    end
  end

  // Address / count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      beats_q <= '0;
    end else begin
      addr_q  <= addr_d;
      beats_q <= beats_d;
    end
  end

  assign addr = addr_q;
  assign last = (beats_q == (CNT_WIDTH+1)'(1));
endmodule

// File: rtl/mem_model_burst_sched.sv
// Pops burst commands and sequences them into per-word memory accesses.
module mem_model_burst_sched
  import mem_model_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 12,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_INCR  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  mem_model_burst_sched_if.master  bus,
  output logic                     busy,
  output logic                     burst_done
);
  localparam int CNT_LSB = cnt_lsb(ADDR_WIDTH);
  localparam int RNW_BIT = rnw_bit(ADDR_WIDTH, CNT_WIDTH);

  state_e                state_q, state_d;
  logic                  rnw_q, rnw_d;
  logic                  done_q, done_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  load, step, last;
  logic                  q_read, mem_write, mem_read, wd_ready;

  mem_model_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .ADDR_INCR  (ADDR_INCR)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .step      (step),
    .load_addr (bus.q_rdata[ADDR_LSB +: ADDR_WIDTH]),
    .load_cnt  (bus.q_rdata[CNT_LSB +: CNT_WIDTH]),
    .addr      (bus.mem_addr),
    .last      (last)
  );

  // Next state, handshake gating and beat generation; clr kills every transfer.
  always_comb begin
    state_d    = state_q;
    rnw_d      = rnw_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    load       = 1'b0;
    step       = 1'b0;
    q_read     = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    wd_ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.q_empty && !clr) begin
          q_read  = 1'b1;
          load    = 1'b1;
          rnw_d   = bus.q_rdata[RNW_BIT];
          state_d = BURST;
        end
      end
      BURST: begin
        if (clr) begin
          state_d = IDLE;
        end else begin
          if (rnw_q) begin
            mem_read = 1'b1;
            if (!bus.mem_wait) begin
              step       = 1'b1;
              rd_valid_d = 1'b1;
              rd_data_d  = bus.mem_readdata;
            end
          end else begin
            mem_write = bus.wd_valid;
            wd_ready  = bus.wd_valid & ~bus.mem_wait;
            step      = wd_ready;
          end
          if (step && last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rnw_q      <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rnw_q      <= rnw_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.q_read        = q_read;
  assign bus.mem_write     = mem_write;
  assign bus.mem_read      = mem_read;
  assign bus.wd_ready      = wd_ready;
  assign bus.mem_writedata = bus.wd_data;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = rd_data_q;
  assign busy              = (state_q == BURST);
  assign burst_done        = done_q;
endmodule

// File: tb/tb_mem_model_burst_sched.sv
// Directed bench for the burst scheduler: hand-computed expectations per cycle.
module tb_mem_model_burst_sched;
  localparam int AW = 32;
  localparam int CW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clr = 1'b0;
  logic busy, burst_done;
  int   checks = 0;
  int   errors = 0;

  mem_model_burst_sched_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .DATA_WIDTH(DW)) bus ();

  mem_model_burst_sched #(
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW),
    .DATA_WIDTH (DW),
    .ADDR_INCR  (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .bus        (bus),
    .busy       (busy),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW+CW:0] cmd(input logic rnw, input logic [CW-1:0] cnt,
                                         input logic [AW-1:0] addr);
    return {rnw, cnt, addr};
  endfunction

  initial begin
    int nbeats;
    int hold4;
    logic [5:0] wait_pat;
    logic [AW-1:0] exp_addr;

    bus.q_empty      = 1'b1;
    bus.q_rdata      = '0;
    bus.mem_readdata = '0;
    bus.mem_wait     = 1'b0;
    bus.wd_valid     = 1'b0;
    bus.wd_data      = '0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_q_read", bus.q_read, 0);
    next();
    reset_n = 1'b1;
    next();

    // 4-beat write at 0x1000, data always valid, no wait
    bus.q_empty = 1'b0; bus.q_rdata = cmd(1'b0, 12'd4, 32'h1000);
    bus.wd_valid = 1'b1; bus.wd_data = 32'h1111_2222;
    @(negedge clk);
    chk("w_pop", bus.q_read, 1);
    chk("w_pop_busy", busy, 0);
    next();
    bus.q_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("w_addr", bus.mem_addr, 64'h1000 + 64'(4 * i));
      chk("w_ready", bus.wd_ready, 1);
      chk("w_wdata", bus.mem_writedata, 64'h1111_2222);
      chk("w_nodone", burst_done, 0);
      next();
    end
    @(negedge clk);
    chk("w_done", burst_done, 1);
    chk("w_idle", busy, 0);
    bus.wd_valid = 1'b0;
    next();

    // 2-beat read at 0x20
    bus.q_empty = 1'b0; bus.q_rdata = cmd(1'b1, 12'd2, 32'h20);
    @(negedge clk);
    chk("r_pop", bus.q_read, 1);
    next();
    bus.q_empty = 1'b1; bus.mem_readdata = 32'hA5;
    @(negedge clk);
    chk("r_req0", bus.mem_read, 1);
    chk("r_addr0", bus.mem_addr, 64'h20);
    chk("r_vld0", bus.rd_valid, 0);
    next();
    bus.mem_readdata = 32'h5A;
    @(negedge clk);
    chk("r_vld1", bus.rd_valid, 1);
    chk("r_data1", bus.rd_data, 64'hA5);
    chk("r_addr1", bus.mem_addr, 64'h24);
    next();
    @(negedge clk);
    chk("r_vld2", bus.rd_valid, 1);
    chk("r_data2", bus.rd_data, 64'h5A);
    chk("r_noreq", bus.mem_read, 0);
    chk("r_done", burst_done, 1);
    next();
    @(negedge clk);
    chk("r_vld3", bus.rd_valid, 0);
    next();

    // 3-beat write at 0, memory stalls 3 cycles on beat 2
    bus.q_empty = 1'b0; bus.q_rdata = cmd(1'b0, 12'd3, 32'h0);
    bus.wd_valid = 1'b1;
    @(negedge clk);
    chk("s_pop", bus.q_read, 1);
    next();
    bus.q_empty = 1'b1;
    wait_pat = 6'b001110;  // bit i = mem_wait in beat cycle i
    nbeats = 0; hold4 = 0;
    for (int i = 0; i < 6; i++) begin
      bus.mem_wait = wait_pat[i];
      @(negedge clk);
      exp_addr = (i == 0) ? 32'h0 : (i == 5) ? 32'h8 : 32'h4;
      chk("s_addr", bus.mem_addr, 64'(exp_addr));
      chk("s_req", bus.mem_write, 1);
      chk("s_ready", bus.wd_ready, 64'(!wait_pat[i]));
      if (bus.wd_ready === 1'b1) nbeats++;
      if (bus.mem_addr === 32'h4) hold4++;
      next();
    end
    bus.mem_wait = 1'b0;
    @(negedge clk);
    chk("s_beats", 64'(nbeats), 3);
    chk("s_hold4", 64'(hold4), 4);
    chk("s_done", burst_done, 1);
    bus.wd_valid = 1'b0;
    next();

    // Back-to-back: 1-beat write then 1-beat read
    bus.q_empty = 1'b0; bus.q_rdata = cmd(1'b0, 12'd1, 32'h100);
    bus.wd_valid = 1'b1;
    @(negedge clk);
    chk("b_pop0", bus.q_read, 1);
    next();
    bus.q_rdata = cmd(1'b1, 12'd1, 32'h200);
    @(negedge clk);
    chk("b_nopop_busy", bus.q_read, 0);
    chk("b_wbeat", bus.wd_ready, 1);
    chk("b_waddr", bus.mem_addr, 64'h100);
    next();
    bus.wd_valid = 1'b0;
    @(negedge clk);
    chk("b_pop1", bus.q_read, 1);
    chk("b_done0", burst_done, 1);
    next();
    bus.q_empty = 1'b1; bus.mem_readdata = 32'h77;
    @(negedge clk);
    chk("b_rbeat", bus.mem_read, 1);
    chk("b_raddr", bus.mem_addr, 64'h200);
    next();
    @(negedge clk);
    chk("b_rdata", bus.rd_data, 64'h77);
    chk("b_done1", burst_done, 1);
    next();

    // Count 0 => 4096-beat read, address wraps through zero
    bus.q_empty = 1'b0; bus.q_rdata = cmd(1'b1, 12'd0, 32'hFFFF_FFFC);
    bus.mem_readdata = 32'hCAFE;
    @(negedge clk);
    chk("l_pop", bus.q_read, 1);
    next();
    bus.q_empty = 1'b1;
    nbeats = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (i == 0) chk("l_addr0", bus.mem_addr, 64'hFFFF_FFFC);
      if (i == 1) chk("l_addr1", bus.mem_addr, 64'h0);
      if (i == 2) chk("l_addr2", bus.mem_addr, 64'h4);
      if (i == 4095) begin
        chk("l_addr_last", bus.mem_addr, 64'h3FF8);
        chk("l_busy_last", busy, 1);
        chk("l_nodone", burst_done, 0);
      end
      if (bus.mem_read === 1'b1) nbeats++;
      next();
    end
    @(negedge clk);
    chk("l_beats", 64'(nbeats), 4096);
    chk("l_done", burst_done, 1);
    chk("l_rdata", bus.rd_data, 64'hCAFE);
    next();

    // clr on beat 2 of 8; then clr blocks a pop in IDLE
    bus.q_empty = 1'b0; bus.q_rdata = cmd(1'b0, 12'd8, 32'h300);
    bus.wd_valid = 1'b1;
    @(negedge clk);
    chk("c_pop", bus.q_read, 1);
    next();
    bus.q_empty = 1'b1;
    @(negedge clk);
    chk("c_beat1", bus.wd_ready, 1);
    next();
    clr = 1'b1;
    @(negedge clk);
    chk("c_nowrite", bus.mem_write, 0);
    chk("c_noready", bus.wd_ready, 0);
    next();
    bus.q_empty = 1'b0; bus.q_rdata = cmd(1'b0, 12'd8, 32'h400);
    @(negedge clk);
    chk("c_idle", busy, 0);
    chk("c_nodone", burst_done, 0);
    chk("c_nopop", bus.q_read, 0);
    chk("c_addr_held", bus.mem_addr, 64'h304);
    next();
    clr = 1'b0;
    @(negedge clk);
    chk("c_pop2", bus.q_read, 1);
    next();
    bus.q_empty = 1'b1;
    @(negedge clk);
    chk("c2_addr", bus.mem_addr, 64'h400);
    chk("c2_ready", bus.wd_ready, 1);
    next();

    // Asynchronous reset mid-burst
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_addr", bus.mem_addr, 0);
    chk("ar_write", bus.mem_write, 0);
    chk("ar_rd_valid", bus.rd_valid, 0);
    chk("ar_rd_data", bus.rd_data, 0);
    chk("ar_done", burst_done, 0);
    next();
    reset_n = 1'b1;
    bus.wd_valid = 1'b0;
    @(negedge clk);
    chk("ar_stay_idle", busy, 0);
    next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
